// File: rtl/dense_vec_packer.sv
// dense_vec_packer: collects a serial stream of fixed-point elements into one
// NB-element vector for a dense layer, then holds it until the layer takes it.
//
// A vector closes on an accepted s_last beat or when slot NB-1 is written,
// whichever comes first. len_err flags a vector that closed early (s_last
// before slot NB-1) or late (slot NB-1 written without s_last). Slots that a
// vector never wrote read as zero.
//
// Build option: define DENSE_PACK_DBUF_EN to add a shadow fill buffer. The
// stream then keeps flowing while a finished vector waits in HOLD, and a
// completed shadow vector replaces the held one without a vec_valid bubble.
module dense_vec_packer #(
    parameter int unsigned fixed = 32,
    parameter int unsigned NB    = 42
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [fixed-1:0]    s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [NB*fixed-1:0] vec,
    output logic                vec_valid,
    input  logic                vec_ready,
    output logic                len_err
);

    localparam int unsigned     CntW     = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CntW-1:0] LastSlot = CntW'(NB - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    // Control state
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            s_ready_q;
    logic            vec_valid_q;
    logic            len_err_q;

    // Output vector buffer; this is what vec shows
    logic [fixed-1:0] buf_q [NB];

    // Beat bookkeeping for the primary buffer
    logic accept;
    logic fill_beat;
    logic fill_at_last;
    logic fill_done;
    logic fill_err;
    logic release_vec;

    assign accept       = s_valid && s_ready_q;
    assign fill_beat    = accept && (state_q == StFill);
    assign fill_at_last = (cnt_q == LastSlot);
    assign fill_done    = fill_beat && (s_last || fill_at_last);
    // Mismatch when s_last and the final slot disagree
    assign fill_err     = s_last ^ fill_at_last;
    // vec_valid is high throughout HOLD, so vec_ready outside HOLD is ignored
    assign release_vec  = (state_q == StHold) && vec_ready;

`ifdef DENSE_PACK_DBUF_EN
    // Shadow buffer, filled while the primary vector sits in HOLD
    logic [fixed-1:0] shd_q [NB];
    logic [fixed-1:0] shd_next [NB];
    logic [CntW-1:0]  shd_cnt_q;
    logic             shd_full_q;
    logic             shd_err_q;

    logic hold_beat;
    logic shd_at_last;
    logic shd_done;
    logic shd_err_beat;

    assign hold_beat    = accept && (state_q == StHold);
    assign shd_at_last  = (shd_cnt_q == LastSlot);
    assign shd_done     = hold_beat && (s_last || shd_at_last);
    assign shd_err_beat = s_last ^ shd_at_last;

    // Shadow contents including this cycle's beat, so a hand-off on the same
    // edge as a shadow write carries the new element along
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            shd_next[i] = shd_q[i];
            if (hold_beat && (shd_cnt_q == CntW'(i))) begin
                shd_next[i] = s_data;
            end
        end
    end

    // Shadow storage: written in HOLD, emptied whenever the held vector leaves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                shd_q[i] <= '0;
            end
        end else if (release_vec) begin
            for (int i = 0; i < NB; i++) begin
                shd_q[i] <= '0;
            end
        end else if (hold_beat) begin
            for (int i = 0; i < NB; i++) begin
                if (shd_cnt_q == CntW'(i)) begin
                    shd_q[i] <= s_data;
                end
            end
        end
    end
`endif

    // Primary buffer: slot writes while filling; on hand-off it is either
    // cleared or reloaded from the shadow so no stale slot survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                buf_q[i] <= '0;
            end
        end else if (release_vec) begin
            for (int i = 0; i < NB; i++) begin
`ifdef DENSE_PACK_DBUF_EN
                buf_q[i] <= shd_next[i];
`else
                buf_q[i] <= '0;
`endif
            end
        end else if (fill_beat) begin
            for (int i = 0; i < NB; i++) begin
                if (cnt_q == CntW'(i)) begin
                    buf_q[i] <= s_data;
                end
            end
        end
    end

    // FILL/HOLD controller with registered s_ready, vec_valid and len_err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
`ifdef DENSE_PACK_DBUF_EN
            shd_cnt_q   <= '0;
            shd_full_q  <= 1'b0;
            shd_err_q   <= 1'b0;
`endif
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                StFill: begin
                    s_ready_q <= 1'b1;
                    if (fill_beat) begin
                        if (fill_done) begin
                            state_q     <= StHold;
                            cnt_q       <= '0;
                            vec_valid_q <= 1'b1;
                            len_err_q   <= fill_err;
`ifndef DENSE_PACK_DBUF_EN
                            // Single buffer: nowhere to put beats until released
                            s_ready_q   <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                end
                StHold: begin
`ifdef DENSE_PACK_DBUF_EN
                    if (vec_ready) begin
                        shd_cnt_q  <= '0;
                        shd_full_q <= 1'b0;
                        s_ready_q  <= 1'b1;
                        if (shd_full_q) begin
                            // Finished shadow becomes vec; vec_valid stays up
                            len_err_q <= shd_err_q;
                        end else if (shd_done) begin
                            // Shadow completes on the hand-off edge itself
                            len_err_q <= shd_err_beat;
                        end else begin
                            // Partial shadow continues filling as the primary
                            state_q     <= StFill;
                            vec_valid_q <= 1'b0;
                            cnt_q       <= shd_cnt_q + CntW'(hold_beat);
                        end
                    end else if (shd_done) begin
                        // Both buffers occupied: stall the stream
                        shd_full_q <= 1'b1;
                        shd_err_q  <= shd_err_beat;
                        shd_cnt_q  <= '0;
                        s_ready_q  <= 1'b0;
                    end else if (hold_beat) begin
                        shd_cnt_q <= shd_cnt_q + CntOne;
                    end
`else
                    if (vec_ready) begin
                        state_q     <= StFill;
                        cnt_q       <= '0;
                        vec_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    // Flatten the buffer onto the vector port, element i at vec[i*fixed +: fixed]
    for (genvar g = 0; g < NB; g++) begin : g_slot
        assign vec[g*fixed +: fixed] = buf_q[g];
    end

    assign s_ready   = s_ready_q;
    assign vec_valid = vec_valid_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_dense_vec_packer.sv
// Self-checking bench for dense_vec_packer: directed scenarios plus a random
// phase, all scored against a queue-based model of vectors built from the
// accepted beats.
module tb_dense_vec_packer;

    localparam int W  = 32;
    localparam int NB = 42;
`ifdef DENSE_PACK_DBUF_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [W-1:0]    s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [NB*W-1:0] vec;
    logic            vec_valid;
    logic            vec_ready = 1'b1;
    logic            len_err;

    always #5 clk = ~clk;

    dense_vec_packer #(
        .fixed(W),
        .NB   (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .vec      (vec),
        .vec_valid(vec_valid),
        .vec_ready(vec_ready),
        .len_err  (len_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: completed vectors waiting for the consumer, and the
    // elements of the vector currently being gathered
    typedef struct packed {
        logic            err;
        logic [NB*W-1:0] data;
    } exp_t;

    exp_t            exp_q[$];
    logic [W-1:0]    cur_q[$];
    exp_t            ent;
    logic [NB*W-1:0] front;
    logic [NB*W-1:0] build;
    logic            shown   = 1'b0;
    logic            up      = 1'b0;
    logic            prev_vv = 1'b0;
    int              rises   = 0;

    // True once a clock edge has seen reset released
    always @(posedge clk or negedge rst) begin
        if (!rst) up <= 1'b0;
        else      up <= 1'b1;
    end

    // Scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            cur_q.delete();
            shown   = 1'b0;
            prev_vv = 1'b0;
            check_eq("rst_vec_valid", vec_valid, 1'b0);
            check_eq("rst_s_ready", s_ready, 1'b0);
            check_eq("rst_len_err", len_err, 1'b0);
            for (int i = 0; i < NB; i++) check_eq("rst_vec_slot", vec[i*W +: W], '0);
        end else begin
            if (vec_valid && !prev_vv) rises++;
            prev_vv = vec_valid;
            check_eq("vec_valid", vec_valid, exp_q.size() > 0);
            check_eq("s_ready", s_ready, up && (exp_q.size() < Cap));
            if (exp_q.size() > 0) begin
                front = exp_q[0].data;
                check_eq("len_err", len_err, shown ? 1'b0 : exp_q[0].err);
                shown = 1'b1;
                for (int i = 0; i < NB; i++) check_eq("vec_slot", vec[i*W +: W], front[i*W +: W]);
                if (vec_ready) begin
                    void'(exp_q.pop_front());
                    shown = 1'b0;
                end
            end else begin
                check_eq("len_err_idle", len_err, 1'b0);
            end
            if (s_valid && s_ready) begin
                cur_q.push_back(s_data);
                if (s_last || cur_q.size() == NB) begin
                    build = '0;
                    foreach (cur_q[i]) build[i*W +: W] = cur_q[i];
                    ent.err  = !(s_last && cur_q.size() == NB);
                    ent.data = build;
                    exp_q.push_back(ent);
                    cur_q.delete();
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        logic acc;
        acc     = 1'b0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq("beat_accepted", acc, 1'b1);
    endtask

    initial begin
        int r0;
        int hi;
        int acc;

        // Reset values and s_ready release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_vec_valid", vec_valid, 1'b0);
        check_eq("reset_s_ready", s_ready, 1'b0);
        check_eq("reset_slot0", vec[W-1:0], '0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("s_ready_before_edge", s_ready, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("s_ready_after_rst", s_ready, 1'b1);
        next_cycle();

        // Full vector 1..NB with s_last on the final beat
        for (int i = 1; i <= NB; i++) send_beat(W'(i), i == NB);
        @(negedge clk);
        check_eq("full_valid", vec_valid, 1'b1);
        check_eq("full_slot0", vec[W-1:0], 1);
        check_eq("full_slot_last", vec[(NB-1)*W +: W], NB);
        check_eq("full_len_err", len_err, 1'b0);
        next_cycle();

        // Short vector of 10 beats
        for (int i = 1; i <= 10; i++) send_beat(32'hA5A5_A5A5, i == 10);
        @(negedge clk);
        check_eq("short_valid", vec_valid, 1'b1);
        check_eq("short_slot9", vec[9*W +: W], 32'hA5A5_A5A5);
        check_eq("short_slot10", vec[10*W +: W], '0);
        check_eq("short_slot_last", vec[(NB-1)*W +: W], '0);
        check_eq("short_len_err", len_err, 1'b1);
        next_cycle();

        // Backpressure: consumer stalls 20 cycles while the stream keeps offering
        vec_ready = 1'b0;
        for (int i = 1; i <= NB; i++) send_beat(W'(100 + i), i == NB);
        hi      = 0;
        acc     = 0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s_data = $urandom;
            @(negedge clk);
            if (vec_valid) hi++;
            if (s_ready) acc++;
            next_cycle();
        end
        s_valid = 1'b0;
        check_eq("bp_valid_cycles", hi, 20);
        check_eq("bp_beats_taken", acc, (Cap == 2) ? 20 : 0);
        vec_ready = 1'b1;
        repeat (3) next_cycle();

        // Reset while a vector is held: it must never reappear
        vec_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send_beat(W'(200 + i), i == 3);
        repeat (2) next_cycle();
        r0  = rises;
        rst = 1'b0;
        repeat (2) next_cycle();
        rst       = 1'b1;
        vec_ready = 1'b1;
        repeat (5) next_cycle();
        check_eq("hold_rst_no_valid", rises - r0, 0);

        // Reset mid-fill, then a full vector
        for (int i = 1; i <= 5; i++) send_beat(W'(900 + i), 1'b0);
        rst = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        r0 = rises;
        for (int i = 1; i <= NB; i++) send_beat(W'(1000 + i), i == NB);
        @(negedge clk);
        check_eq("rstfill_slot0", vec[W-1:0], 1001);
        check_eq("rstfill_slot4", vec[4*W +: W], 1005);
        next_cycle();
        repeat (3) next_cycle();
        check_eq("rstfill_one_valid", rises - r0, 1);

        // Missing s_last: vector closes at slot NB-1, next beat starts a new one
        for (int i = 1; i <= NB; i++) send_beat(W'(2000 + i), 1'b0);
        @(negedge clk);
        check_eq("miss_valid", vec_valid, 1'b1);
        check_eq("miss_len_err", len_err, 1'b1);
        check_eq("miss_slot_last", vec[(NB-1)*W +: W], 2000 + NB);
        next_cycle();
        send_beat(32'h0000_DEAD, 1'b1);
        @(negedge clk);
        check_eq("miss_next_slot0", vec[W-1:0], 32'h0000_DEAD);
        check_eq("miss_next_slot1", vec[W +: W], '0);
        check_eq("miss_next_len_err", len_err, 1'b1);
        next_cycle();

        // Random traffic and consumer stalls, with one reset in the middle
        for (int c = 0; c < 1500; c++) begin
            s_valid   = ($urandom_range(3) != 0);
            s_data    = $urandom;
            s_last    = ($urandom_range(15) == 0);
            vec_ready = ($urandom_range(2) != 0);
            if (c == 600) rst = 1'b0;
            if (c == 603) rst = 1'b1;
            next_cycle();
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        vec_ready = 1'b1;
        repeat (10) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
